// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-mode VRAM arbiter.
//   VRAM_WORDS / CTRL_ADDR : default memory map (VRAM words, then the control register)
//   arb_state_t            : arbiter FSM states
//   addr_region_t          : decoded CPU address region
//   decode_addr()          : maps a word address onto VRAM / CTRL / OOR
package vga_text_pkg;

  localparam int unsigned VRAM_WORDS = 600;
  localparam int unsigned CTRL_ADDR  = 600;

  typedef enum logic {IDLE, RD_RET} arb_state_t;

  typedef enum logic [1:0] {ADDR_VRAM, ADDR_CTRL, ADDR_OOR} addr_region_t;

  function automatic addr_region_t decode_addr(input int unsigned addr,
                                               input int unsigned vram_words,
                                               input int unsigned ctrl_addr);
    if (addr < vram_words)       return ADDR_VRAM;
    else if (addr == ctrl_addr)  return ADDR_CTRL;
    else                         return ADDR_OOR;
  endfunction

endpackage

// File: rtl/vram_stall_monitor.sv
// Counts consecutive cycles in which the CPU is held off by the display and
// raises a sticky STARVED flag once the count reaches STALL_LIMIT.
//   clk_i, rst_ni   : clock, async active-low reset
//   blocked_i       : CPU blocked by a display fetch this cycle
//   clear_i         : CPU completed or dropped its request (restart count)
//   starved_clr_i   : clears the sticky flag (loses against a simultaneous set)
//   starved_o       : sticky starvation flag
module vram_stall_monitor #(
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic blocked_i,
  input  logic clear_i,
  input  logic starved_clr_i,
  output logic starved_o
);

  localparam int unsigned      CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starved_q, starved_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                           cnt_d = '0;
    else if (blocked_i && cnt_q != LIMIT)  cnt_d = cnt_q + 1'b1;

    starved_d = starved_q;
    if (starved_clr_i) starved_d = 1'b0;
    // Evaluated after the clear so that a set in the same cycle wins.
    if (cnt_d == LIMIT) starved_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      starved_q <= starved_d;
    end
  end

  assign starved_o = starved_q;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Arbitrates the single-port text VRAM between the Avalon CPU slave and the
// VGA character fetch, and holds the text-mode control register.
//   CLK, RESET_N             : clock, async active-low reset
//   AVL_*                    : Avalon-MM slave (CPU), stalled via AVL_WAITREQ
//   DISP_REQ/ADDR            : display fetch, always accepted, absolute priority
//   DISP_RDATA/RVALID        : fetched word, one cycle after DISP_REQ
//   RAM_*                    : VRAM port (1-cycle synchronous read)
//   CTRL_REG                 : control register to the colour mapper
//   STARVED / STARVED_CLR    : sticky CPU starvation flag and its clear
//
// state  | meaning
// IDLE   | accept CPU accesses when the display does not need the RAM
// RD_RET | VRAM read issued last cycle; return RAM_RDATA to the CPU
module vga_vram_arbiter #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned VRAM_WORDS  = vga_text_pkg::VRAM_WORDS,
  parameter int unsigned CTRL_ADDR   = vga_text_pkg::CTRL_ADDR,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic              AVL_WRITE,
  input  logic [3:0]        AVL_BYTE_EN,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  input  logic [DATA_W-1:0] AVL_WRITEDATA,
  output logic [DATA_W-1:0] AVL_READDATA,
  output logic              AVL_WAITREQ,
  input  logic              DISP_REQ,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  output logic [DATA_W-1:0] DISP_RDATA,
  output logic              DISP_RVALID,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE,
  output logic [3:0]        RAM_BE,
  output logic [DATA_W-1:0] RAM_WDATA,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic [DATA_W-1:0] CTRL_REG,
  output logic              STARVED,
  input  logic              STARVED_CLR
);

  import vga_text_pkg::*;

  arb_state_t    state_q, state_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic          disp_vld_q;
  logic          cpu_req, cpu_done, blocked, ctrl_we;
  addr_region_t  region;

  assign cpu_req = AVL_CS & (AVL_READ | AVL_WRITE);
  assign region  = decode_addr(32'(AVL_ADDR), VRAM_WORDS, CTRL_ADDR);

  always_comb begin
    state_d      = state_q;
    RAM_ADDR     = '0;
    RAM_WE       = 1'b0;
    RAM_BE       = '0;
    RAM_WDATA    = '0;
    AVL_WAITREQ  = 1'b1;
    AVL_READDATA = '0;
    ctrl_we      = 1'b0;
    blocked      = 1'b0;

    if (DISP_REQ) RAM_ADDR = DISP_ADDR;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          unique case (region)
            ADDR_CTRL: begin
              AVL_WAITREQ = 1'b0;
              ctrl_we     = AVL_WRITE;
              if (AVL_READ) AVL_READDATA = ctrl_q;
            end
            ADDR_OOR: AVL_WAITREQ = 1'b0;
            default: begin
              if (DISP_REQ) begin
                blocked = 1'b1;
              end else begin
                RAM_ADDR = AVL_ADDR;
                if (AVL_WRITE) begin
                  RAM_WE      = 1'b1;
                  RAM_BE      = AVL_BYTE_EN;
                  RAM_WDATA   = AVL_WRITEDATA;
                  AVL_WAITREQ = 1'b0;
                end else begin
                  state_d = RD_RET;
                end
              end
            end
          endcase
        end
      end
      RD_RET: begin
        state_d = IDLE;
        if (cpu_req) begin
          AVL_WAITREQ  = 1'b0;
          AVL_READDATA = RAM_RDATA;
        end
      end
    endcase

    // The RAM port and the Avalon handshake are combinational, so they are
    // forced to their idle values for as long as reset is held.
    if (!RESET_N) begin
      RAM_ADDR     = '0;
      RAM_WE       = 1'b0;
      RAM_BE       = '0;
      RAM_WDATA    = '0;
      AVL_WAITREQ  = 1'b1;
      AVL_READDATA = '0;
      ctrl_we      = 1'b0;
      blocked      = 1'b0;
      state_d      = IDLE;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_we) begin
      for (int b = 0; b < 4; b++) begin
        if (AVL_BYTE_EN[b]) ctrl_d[8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      disp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      disp_vld_q <= DISP_REQ;
    end
  end

  assign cpu_done    = cpu_req & ~AVL_WAITREQ;
  assign DISP_RVALID = disp_vld_q;
  assign DISP_RDATA  = disp_vld_q ? RAM_RDATA : '0;
  assign CTRL_REG    = ctrl_q;

  vram_stall_monitor #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_monitor (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .blocked_i    (blocked),
    .clear_i      (~cpu_req | cpu_done),
    .starved_clr_i(STARVED_CLR),
    .starved_o    (STARVED)
  );

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares the single-port on-chip text-mode VRAM (32-bit words) between two requesters: the Avalon-MM slave side (NIOS CPU) and the VGA character-fetch side of the text controller.
- The display has absolute priority. The CPU is stalled with waitrequest.
- The block also owns the text-mode control register. It sits between the Avalon slave wrapper, the VRAM instance and the colour mapper.

Parameters:
- ADDR_W, 10, Avalon word-address width.
- DATA_W, 32, data width.
- VRAM_WORDS, 600, number of VRAM words (addresses 0..599).
- CTRL_ADDR, 600, word address of the control register.
- STALL_LIMIT, 16, consecutive blocked CPU cycles that set the STARVED flag.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET_N  in  1  reset. One clock domain; reset is asynchronous and active-low.
- AVL_CS  in  1  Avalon chip select.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_BYTE_EN  in  4  write byte enables.
- AVL_ADDR  in  ADDR_W  word address.
- AVL_WRITEDATA  in  DATA_W  write data.
- AVL_READDATA  out  DATA_W  read data, valid when AVL_WAITREQ=0 during a read.
- AVL_WAITREQ  out  1  stall; the master holds its request while this is 1.
- DISP_REQ  in  1  display fetch request (single cycle). Always accepted.
- DISP_ADDR  in  ADDR_W  fetch address.
- DISP_RDATA  out  DATA_W  fetched word.
- DISP_RVALID  out  1  DISP_RDATA valid, exactly 1 cycle after DISP_REQ.
- RAM_ADDR  out  ADDR_W  VRAM address.
- RAM_WE  out  1  VRAM write enable.
- RAM_BE  out  4  VRAM byte enables.
- RAM_WDATA  out  DATA_W  VRAM write data.
- RAM_RDATA  in  DATA_W  VRAM read data, 1-cycle synchronous latency.
- CTRL_REG  out  DATA_W  control register contents, to the colour mapper.
- STARVED  out  1  sticky flag: the CPU was blocked for STALL_LIMIT or more consecutive cycles.
- STARVED_CLR  in  1  clears STARVED.

Behaviour:
- CPU request: cpu_req = AVL_CS & (AVL_READ | AVL_WRITE). The master never asserts READ and WRITE together.
- At most one RAM operation per cycle.
- Display priority: when DISP_REQ=1, RAM_ADDR=DISP_ADDR, RAM_WE=0. The next cycle has DISP_RVALID=1 and DISP_RDATA=RAM_RDATA.
- FSM states: IDLE, RD_RET.
- IDLE, cpu_req, VRAM address (< VRAM_WORDS), DISP_REQ=0:
  - Write: RAM_WE=1, RAM_BE=AVL_BYTE_EN, RAM_WDATA=AVL_WRITEDATA. AVL_WAITREQ=0 in the same cycle. Stay in IDLE.
  - Read: issue the RAM read with AVL_WAITREQ=1, then go to RD_RET.
- IDLE, cpu_req, DISP_REQ=1: AVL_WAITREQ=1, nothing issued for the CPU. The stall counter increments.
- Control register access (AVL_ADDR == CTRL_ADDR): served in IDLE in the same cycle regardless of DISP_REQ, with AVL_WAITREQ=0.
  - Write updates CTRL_REG per byte enable at the clock edge.
  - Read returns CTRL_REG.
- Out-of-range address (> CTRL_ADDR): completes immediately with AVL_WAITREQ=0. Writes are dropped; reads return 0.
- RD_RET:
  - AVL_WAITREQ=0 and AVL_READDATA=RAM_RDATA, combinational pass-through, valid this cycle only.
  - No CPU operation is issued in RD_RET; a display request is still serviced normally.
  - Next state is IDLE unconditionally.
- Read latency (unblocked): 2 cycles. Write latency (unblocked): 1 cycle.
- AVL_WAITREQ is 1 whenever cpu_req=0 or the block is in reset.
- AVL_READDATA is 0 whenever AVL_WAITREQ=1.
- Stall counter:
  - Increments in each IDLE cycle where cpu_req=1 and the CPU is blocked by the display. It saturates at STALL_LIMIT.
  - Resets to 0 on any CPU completion or when cpu_req=0.
  - STARVED is set when the counter reaches STALL_LIMIT. It is cleared by STARVED_CLR; if set and clear happen in the same cycle, set wins.
- Reset (async, any state):
  - State = IDLE, counter = 0, STARVED = 0, CTRL_REG = 0, DISP_RVALID = 0.
  - RAM_WE = 0, RAM_BE = 0, RAM_ADDR = 0, RAM_WDATA = 0, AVL_WAITREQ = 1.
  - A read in flight at reset is discarded; the master re-issues it.
- DISP_RVALID/DISP_RDATA come from a registered valid bit; DISP_RDATA is 0 when DISP_RVALID=0.

Decomposition:
- Package vga_text_pkg holds:
  - the VRAM_WORDS and CTRL_ADDR constants;
  - the state typedef enum logic {IDLE, RD_RET} arb_state_t;
  - the address-decode function returning VRAM / CTRL / OOR.
- One natural sub-module: vram_stall_monitor (saturating counter plus sticky STARVED). Everything else stays flat.

Test Plan:
- Unblocked write/read: write 0xDEADBEEF to addr 5 with BE=4'hF → RAM_WE pulse in cycle 0 with WAITREQ=0. Read addr 5 → WAITREQ=1, 0; READDATA=0xDEADBEEF in cycle 1.
- Display collision: CPU read addr 7 while DISP_REQ=1 for 3 cycles (addr 10..12) → CPU blocked 3 cycles, DISP_RVALID on each following cycle with the correct data; CPU read completes at cycle 4 with the addr-7 data.
- Byte enables and control register: write 0x11223344 to CTRL_ADDR with BE=4'b0101 over a prior value of 0 → CTRL_REG=0x00220044; read returns the same with no wait, even with DISP_REQ=1.
- Out of range: write to 700 → immediate completion, VRAM unchanged. Read 700 → returns 0.
- Starvation: hold DISP_REQ=1 for 20 cycles with a pending CPU write → STARVED rises after 16 blocked cycles; pulse STARVED_CLR → 0.
- Reset mid-read: assert RESET_N=0 in RD_RET → immediate WAITREQ=1, CTRL_REG=0, DISP_RVALID=0; after release, a re-issued read completes in 2 cycles.
